// File: rtl/axi_stream_pkg.sv
// -----------------------------------------------------------------------------
// axi_stream_pkg
// Shared helpers for the AXI-Stream packet position tracker.
//   bytes_per_word(data_width)  : number of bytes carried by one tdata word
//   word_of_byte(byte_idx, bpw) : index of the word that holds byte byte_idx
// -----------------------------------------------------------------------------
package axi_stream_pkg;

  function automatic int bytes_per_word(input int data_width);
    return data_width / 8;
  endfunction

  function automatic int word_of_byte(input int byte_idx, input int bpw);
    return byte_idx / bpw;
  endfunction

endpackage

// File: rtl/axi_stream_pkt_pos.sv
// -----------------------------------------------------------------------------
// axi_stream_pkt_pos
// Tracks where the word currently on the stream sits inside its packet.
//
// Optional feature macro: AXIS_PKT_OVERFLOW_CHECK_EN
//   defined   -> o_overflow flags packets longer than MAX_PACKET_BYTES
//   undefined -> o_overflow is tied low and no overflow logic exists
//
// Ports:
//   clk          in   clock
//   rst          in   synchronous active-low reset
//   i_xfer       in   a word is accepted this cycle (tvalid && tready)
//   i_last       in   the word on the stream carries tlast
//   i_byte_sel   in   packet byte index to test against the current word
//   o_word_count out  index of the current word within its packet (saturating)
//   o_sop        out  current word is word 0 of a packet
//   o_reached    out  current word holds byte i_byte_sel
//   o_overflow   out  packet has run past MAX_PACKET_BYTES
// -----------------------------------------------------------------------------
module axi_stream_pkt_pos
  import axi_stream_pkg::*;
#(
  parameter int BYTES_PER_WORD   = 8,
  parameter int MAX_PACKET_BYTES = 65536,
  parameter int BPW_LOG          = $clog2(BYTES_PER_WORD),
  parameter int WC_W             = $clog2(MAX_PACKET_BYTES / BYTES_PER_WORD) + 1,
  parameter int BS_W             = $clog2(MAX_PACKET_BYTES)
)(
  input  logic            clk,
  input  logic            rst,
  input  logic            i_xfer,
  input  logic            i_last,
  input  logic [BS_W-1:0] i_byte_sel,
  output logic [WC_W-1:0] o_word_count,
  output logic            o_sop,
  output logic            o_reached,
  output logic            o_overflow
);

  // Common width for comparing the word counter against the selected word.
  localparam int CMP_W = (WC_W > BS_W) ? WC_W : BS_W;

  logic [WC_W-1:0]  r_word_count;
  logic [BS_W-1:0]  w_sel_word;
  logic [CMP_W-1:0] w_sel_word_ext;
  logic [CMP_W-1:0] w_word_count_ext;

  // Word counter: advances on every accepted non-last word, returns to zero
  // after the last word, and sticks at all-ones instead of wrapping so an
  // oversized packet never aliases back onto word 0.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_word_count <= '0;
    end else if (i_xfer) begin
      if (i_last) begin
        r_word_count <= '0;
      end else if (r_word_count != '1) begin
        r_word_count <= r_word_count + 1'b1;
      end
    end
  end

  // A byte index maps to its word by dropping the byte-lane bits, so every
  // byte lane of the current word reports reached.
  assign w_sel_word       = i_byte_sel >> BPW_LOG;
  assign w_sel_word_ext   = CMP_W'(w_sel_word);
  assign w_word_count_ext = CMP_W'(r_word_count);

  assign o_word_count = r_word_count;
  assign o_sop        = (r_word_count == '0);
  assign o_reached    = (w_word_count_ext == w_sel_word_ext);

`ifdef AXIS_PKT_OVERFLOW_CHECK_EN
  localparam int              LIMIT_WORDS = word_of_byte(MAX_PACKET_BYTES, BYTES_PER_WORD);
  localparam logic [WC_W-1:0] LIMIT_WC    = WC_W'(LIMIT_WORDS);

  logic r_overflow;

  // Any word accepted at or beyond the word limit means the packet is too
  // long. The flag lives until the packet ends; the end of packet wins over
  // a simultaneous set so the next packet always starts clean.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_overflow <= 1'b0;
    end else if (i_xfer) begin
      if (i_last) begin
        r_overflow <= 1'b0;
      end else if (r_word_count >= LIMIT_WC) begin
        r_overflow <= 1'b1;
      end
    end
  end

  assign o_overflow = r_overflow;
`else
  assign o_overflow = 1'b0;
`endif

endmodule

// File: rtl/axi_stream_packet_if.sv
// -----------------------------------------------------------------------------
// axi_stream_packet_if
// Zero-latency AXI-Stream pass-through with packet position tracking.
//
// Optional feature macro: AXIS_PKT_OVERFLOW_CHECK_EN (enables overflow flag).
//
// Parameters:
//   DATA_WIDTH        tdata width, multiple of 8
//   USER_WIDTH        tuser width
//   TKEEP             1: forward tkeep, 0: drive m_tkeep all-ones
//   MAX_PACKET_BYTES  largest legal packet size in bytes
//
// Ports:
//   clk, rst                        clock, synchronous active-low reset
//   s_tdata/tuser/tkeep/tlast/tvalid, s_tready   slave stream
//   m_tdata/tuser/tkeep/tlast/tvalid, m_tready   master stream
//   byte_sel    in   packet byte index to test
//   reached     out  current word holds byte byte_sel
//   sop         out  current word is word 0 of a packet
//   word_count  out  index of current word within its packet
//   overflow    out  packet exceeded MAX_PACKET_BYTES
// -----------------------------------------------------------------------------
module axi_stream_packet_if
  import axi_stream_pkg::*;
#(
  parameter int  DATA_WIDTH       = 64,
  parameter int  USER_WIDTH       = 1,
  parameter int  TKEEP            = 1,
  parameter int  MAX_PACKET_BYTES = 65536,
  localparam int BYTES_PER_WORD   = bytes_per_word(DATA_WIDTH),
  localparam int BPW_LOG          = $clog2(BYTES_PER_WORD),
  localparam int WC_W             = $clog2(MAX_PACKET_BYTES / BYTES_PER_WORD) + 1,
  localparam int BS_W             = $clog2(MAX_PACKET_BYTES)
)(
  input  logic                      clk,
  input  logic                      rst,
  // slave stream
  input  logic [DATA_WIDTH-1:0]     s_tdata,
  input  logic [USER_WIDTH-1:0]     s_tuser,
  input  logic [BYTES_PER_WORD-1:0] s_tkeep,
  input  logic                      s_tlast,
  input  logic                      s_tvalid,
  output logic                      s_tready,
  // master stream
  output logic [DATA_WIDTH-1:0]     m_tdata,
  output logic [USER_WIDTH-1:0]     m_tuser,
  output logic [BYTES_PER_WORD-1:0] m_tkeep,
  output logic                      m_tlast,
  output logic                      m_tvalid,
  input  logic                      m_tready,
  // position tracking
  input  logic [BS_W-1:0]           byte_sel,
  output logic                      reached,
  output logic                      sop,
  output logic [WC_W-1:0]           word_count,
  output logic                      overflow
);

  logic w_xfer;

  // Pass-through stays purely combinational, including during reset.
  assign m_tdata  = s_tdata;
  assign m_tuser  = s_tuser;
  assign m_tlast  = s_tlast;
  assign m_tvalid = s_tvalid;
  assign s_tready = m_tready;

  generate
    if (TKEEP != 0) begin : g_keep
      assign m_tkeep = s_tkeep;
    end else begin : g_no_keep
      logic w_unused_keep;
      assign w_unused_keep = ^s_tkeep;
      assign m_tkeep       = '1;
    end
  endgenerate

  assign w_xfer = s_tvalid && m_tready;

  axi_stream_pkt_pos #(
    .BYTES_PER_WORD   (BYTES_PER_WORD),
    .MAX_PACKET_BYTES (MAX_PACKET_BYTES),
    .BPW_LOG          (BPW_LOG),
    .WC_W             (WC_W),
    .BS_W             (BS_W)
  ) u_pos (
    .clk          (clk),
    .rst          (rst),
    .i_xfer       (w_xfer),
    .i_last       (s_tlast),
    .i_byte_sel   (byte_sel),
    .o_word_count (word_count),
    .o_sop        (sop),
    .o_reached    (reached),
    .o_overflow   (overflow)
  );

endmodule

// File: tb/tb_axi_stream_packet_if.sv
module tb_axi_stream_packet_if;
  import axi_stream_pkg::*;

  localparam int DW    = 32;
  localparam int UW    = 2;
  localparam int MAXB  = 16;
  localparam int BPW   = 4;
  localparam int WC_W  = 3;
  localparam int BS_W  = 4;
  localparam int LIMIT = 4;     // MAXB / BPW words
  localparam int WCMAX = 7;     // all-ones of WC_W
`ifdef AXIS_PKT_OVERFLOW_CHECK_EN
  localparam bit OVF_ON = 1'b1;
`else
  localparam bit OVF_ON = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic [DW-1:0]   s_tdata = '0;
  logic [UW-1:0]   s_tuser = '0;
  logic [BPW-1:0]  s_tkeep = '0;
  logic            s_tlast = 1'b0;
  logic            s_tvalid = 1'b0;
  logic            m_tready = 1'b0;
  logic [BS_W-1:0] byte_sel = '0;

  logic            s_tready0, s_tready1;
  logic [DW-1:0]   m_tdata0, m_tdata1;
  logic [UW-1:0]   m_tuser0, m_tuser1;
  logic [BPW-1:0]  m_tkeep0, m_tkeep1;
  logic            m_tlast0, m_tlast1, m_tvalid0, m_tvalid1;
  logic            reached0, reached1, sop0, sop1, ovf0, ovf1;
  logic [WC_W-1:0] wc0, wc1;

  axi_stream_packet_if #(.DATA_WIDTH(DW), .USER_WIDTH(UW), .TKEEP(1), .MAX_PACKET_BYTES(MAXB)) dut0 (
    .clk(clk), .rst(rst),
    .s_tdata(s_tdata), .s_tuser(s_tuser), .s_tkeep(s_tkeep), .s_tlast(s_tlast),
    .s_tvalid(s_tvalid), .s_tready(s_tready0),
    .m_tdata(m_tdata0), .m_tuser(m_tuser0), .m_tkeep(m_tkeep0), .m_tlast(m_tlast0),
    .m_tvalid(m_tvalid0), .m_tready(m_tready),
    .byte_sel(byte_sel), .reached(reached0), .sop(sop0), .word_count(wc0), .overflow(ovf0)
  );

  axi_stream_packet_if #(.DATA_WIDTH(DW), .USER_WIDTH(UW), .TKEEP(0), .MAX_PACKET_BYTES(MAXB)) dut1 (
    .clk(clk), .rst(rst),
    .s_tdata(s_tdata), .s_tuser(s_tuser), .s_tkeep(s_tkeep), .s_tlast(s_tlast),
    .s_tvalid(s_tvalid), .s_tready(s_tready1),
    .m_tdata(m_tdata1), .m_tuser(m_tuser1), .m_tkeep(m_tkeep1), .m_tlast(m_tlast1),
    .m_tvalid(m_tvalid1), .m_tready(m_tready),
    .byte_sel(byte_sel), .reached(reached1), .sop(sop1), .word_count(wc1), .overflow(ovf1)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  bit cmp_en  = 1'b0;

  // Reference model: position of the next word inside the current packet as
  // an unbounded integer, plus the "packet too long" flag.
  int idx = 0;
  bit ovf_m = 1'b0;

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic int exp_wc();
    return (idx > WCMAX) ? WCMAX : idx;
  endfunction

  always @(posedge clk) begin
    if (!rst) begin
      idx   = 0;
      ovf_m = 1'b0;
    end else if (s_tvalid && m_tready) begin
      if (s_tlast) begin
        idx   = 0;
        ovf_m = 1'b0;
      end else begin
        if (OVF_ON && (idx * BPW >= MAXB)) ovf_m = 1'b1;
        idx = idx + 1;
      end
    end
  end

  // Every-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    if (cmp_en) begin
      int  w;
      bit  r;
      w = exp_wc();
      r = (int'(byte_sel) >= w * BPW) && (int'(byte_sel) < (w + 1) * BPW);
      chk("tdata0",  64'(m_tdata0), 64'(s_tdata));
      chk("tdata1",  64'(m_tdata1), 64'(s_tdata));
      chk("tuser0",  64'(m_tuser0), 64'(s_tuser));
      chk("tlast0",  64'(m_tlast0), 64'(s_tlast));
      chk("tvalid0", 64'(m_tvalid0), 64'(s_tvalid));
      chk("tready0", 64'(s_tready0), 64'(m_tready));
      chk("tvalid1", 64'(m_tvalid1), 64'(s_tvalid));
      chk("tkeep0",  64'(m_tkeep0), 64'(s_tkeep));
      chk("tkeep1",  64'(m_tkeep1), 64'hF);
      chk("wc0",     64'(wc0), 64'(w));
      chk("wc1",     64'(wc1), 64'(w));
      chk("sop0",    64'(sop0), 64'(w == 0));
      chk("reached0", 64'(reached0), 64'(r));
      chk("reached1", 64'(reached1), 64'(r));
      chk("ovf0",    64'(ovf0), 64'(ovf_m));
    end
  end

  // One cycle of stimulus: inputs change just after the rising edge, and the
  // task returns at the falling edge where outputs are sampled.
  task automatic step(input bit v, input bit r, input bit l, input bit rn,
                      input logic [BS_W-1:0] bs, input logic [BPW-1:0] kp);
    @(posedge clk);
    #1;
    rst      = rn;
    s_tvalid = v;
    m_tready = r;
    s_tlast  = l;
    byte_sel = bs;
    s_tkeep  = kp;
    s_tdata  = DW'($urandom);
    s_tuser  = UW'($urandom);
    @(negedge clk);
  endtask

  initial begin
    // reset, including a word presented while in reset
    step(0, 1, 0, 0, 4'd5, 4'h0);
    step(1, 1, 0, 0, 4'd5, 4'h0);
    cmp_en = 1'b1;
    chk("rst_wc",     64'(wc0), 64'd0);
    chk("rst_sop",    64'(sop0), 64'd1);
    chk("rst_ovf",    64'(ovf0), 64'd0);
    chk("rst_tvalid", 64'(m_tvalid0), 64'd1);
    step(0, 1, 0, 1, 4'd5, 4'h0);

    // continuous 3-word packet, byte_sel = 5
    step(1, 1, 0, 1, 4'd5, 4'h0);
    chk("p3_w0_wc", 64'(wc0), 64'd0); chk("p3_w0_sop", 64'(sop0), 64'd1); chk("p3_w0_reach", 64'(reached0), 64'd0);
    step(1, 1, 0, 1, 4'd5, 4'h0);
    chk("p3_w1_wc", 64'(wc0), 64'd1); chk("p3_w1_sop", 64'(sop0), 64'd0); chk("p3_w1_reach", 64'(reached0), 64'd1);
    step(1, 1, 1, 1, 4'd5, 4'h0);
    chk("p3_w2_wc", 64'(wc0), 64'd2); chk("p3_w2_reach", 64'(reached0), 64'd0);
    step(0, 1, 0, 1, 4'd5, 4'h0);
    chk("p3_end_wc", 64'(wc0), 64'd0); chk("p3_end_sop", 64'(sop0), 64'd1);

    // stall on word 1 for three cycles
    step(1, 1, 0, 1, 4'd5, 4'h0);
    for (int k = 0; k < 3; k++) begin
      step(1, 0, 0, 1, 4'd5, 4'h0);
      chk("stall_wc", 64'(wc0), 64'd1);
      chk("stall_reach", 64'(reached0), 64'd1);
    end
    step(1, 1, 0, 1, 4'd5, 4'h0);
    chk("stall_go_wc", 64'(wc0), 64'd1);
    step(1, 1, 1, 1, 4'd5, 4'h0);
    chk("stall_last_wc", 64'(wc0), 64'd2);
    step(0, 0, 0, 1, 4'd5, 4'h0);

    // back-to-back single-word packets
    for (int k = 0; k < 2; k++) begin
      step(1, 1, 1, 1, 4'd5, 4'h0);
      chk("single_wc", 64'(wc0), 64'd0);
      chk("single_sop", 64'(sop0), 64'd1);
    end
    step(0, 1, 0, 1, 4'd5, 4'h0);
    chk("single_after_wc", 64'(wc0), 64'd0);

    // reset after word 2 of a 5-word packet
    for (int k = 0; k < 3; k++) step(1, 1, 0, 1, 4'd5, 4'h0);
    step(1, 1, 0, 0, 4'd5, 4'h0);
    chk("midrst_before", 64'(wc0), 64'd3);
    step(1, 1, 0, 1, 4'd5, 4'h0);
    chk("midrst_wc", 64'(wc0), 64'd0); chk("midrst_sop", 64'(sop0), 64'd1);
    step(1, 1, 1, 1, 4'd5, 4'h0);
    chk("midrst_next_wc", 64'(wc0), 64'd1);
    step(0, 1, 0, 1, 4'd5, 4'h0);

    // 6-word packet against a 4-word limit
    for (int k = 0; k < 6; k++) begin
      step(1, 1, (k == 5), 1, 4'd0, 4'h0);
      chk("ovf6", 64'(ovf0), 64'((k == 5) ? OVF_ON : 1'b0));
    end
    step(0, 1, 0, 1, 4'd0, 4'h0);
    chk("ovf6_clear", 64'(ovf0), 64'd0);

    // 10-word packet: counter saturates at 7
    for (int k = 0; k < 10; k++) begin
      step(1, 1, (k == 9), 1, 4'd15, 4'h0);
      chk("sat_wc", 64'(wc0), 64'((k > 7) ? 7 : k));
    end
    chk("sat_ovf", 64'(ovf0), 64'(OVF_ON));
    step(0, 1, 0, 1, 4'd15, 4'h0);
    chk("sat_end_wc", 64'(wc0), 64'd0);

    // tkeep handling
    step(1, 1, 1, 1, 4'd0, 4'b0011);
    chk("tkeep_on",  64'(m_tkeep0), 64'h3);
    chk("tkeep_off", 64'(m_tkeep1), 64'hF);

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      step(($urandom % 10) < 7, ($urandom % 10) < 7, ($urandom % 5) == 0,
           ($urandom % 64) != 0, BS_W'($urandom), BPW'($urandom));
    end

    cmp_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/axi_stream_packet_if.md
AXI_STREAM_PACKET_IF -- requirements
Module: axi_stream_packet_if

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 64: tdata width in bits; must be a multiple of 8.
REQ-002 SHALL have parameter USER_WIDTH, default 1: tuser width in bits.
REQ-003 SHALL have parameter TKEEP, default 1: 1 means the tkeep path is used; 0 means the tkeep output is driven all-ones and the tkeep input is ignored.
REQ-004 SHALL have parameter MAX_PACKET_BYTES, default 65536: largest legal packet size.
REQ-005 SHALL have the following ports and derived widths:
- Derived: BYTES_PER_WORD = DATA_WIDTH/8; BPW_LOG = $clog2(BYTES_PER_WORD); WC_W = $clog2(MAX_PACKET_BYTES/BYTES_PER_WORD)+1; BS_W = $clog2(MAX_PACKET_BYTES).
- Clock and reset: one clock; reset is synchronous and active-low.
  - clk  in  1  clock
  - rst  in  1  synchronous active-low reset
- Slave stream:
  - s_tdata  in  DATA_WIDTH
  - s_tuser  in  USER_WIDTH
  - s_tkeep  in  BYTES_PER_WORD
  - s_tlast  in  1
  - s_tvalid  in  1
  - s_tready  out  1
- Master stream:
  - m_tdata  out  DATA_WIDTH
  - m_tuser  out  USER_WIDTH
  - m_tkeep  out  BYTES_PER_WORD
  - m_tlast  out  1
  - m_tvalid  out  1
  - m_tready  in  1
- Position tracking:
  - byte_sel  in  BS_W  packet byte index to test
  - reached  out  1  the current word contains byte byte_sel
  - sop  out  1  the current word is word 0 of a packet
  - word_count  out  WC_W  index of the current word within its packet
  - overflow  out  1  packet exceeded MAX_PACKET_BYTES

Function
REQ-006 SHALL pass the stream through combinationally with zero latency:
- m_tdata, m_tuser, m_tlast, m_tvalid follow the matching s_* inputs.
- s_tready = m_tready.
- m_tkeep = s_tkeep when TKEEP=1, otherwise all-ones.
REQ-007 SHALL define a transfer as s_tvalid && m_tready in the same cycle.
REQ-008 SHALL change word_count only as follows:
- On a transfer with s_tlast=0: increment by 1.
- On a transfer with s_tlast=1: clear to 0 on the next clock.
- Otherwise: hold.
REQ-009 SHALL saturate word_count at its all-ones value; it SHALL NOT wrap around.
REQ-010 SHALL drive sop = (word_count == 0) combinationally, independent of s_tvalid.
REQ-011 SHALL drive reached = (word_count == byte_sel >> BPW_LOG) combinationally, independent of s_tvalid; reached covers every byte of the current word.
REQ-012 SHALL let a stalled word (s_tvalid && !m_tready) leave word_count, sop and reached unchanged.
REQ-013 SHALL, for a single-word packet (s_tlast=1 while sop=1), keep word_count at 0 after the transfer.
REQ-014 SHALL not constrain the stream: any s_tvalid/m_tready pattern is legal, including back-to-back packets with no idle cycle.

Reset
REQ-015 SHALL, while rst=0 at a rising clk edge, reset word_count to 0 and overflow to 0; reset therefore forces sop=1.
REQ-016 SHALL abandon any packet in progress when reset is applied mid-packet; the next accepted word is treated as word 0.
REQ-017 SHALL keep the pass-through outputs combinational during reset: m_tvalid follows s_tvalid.

Configuration
REQ-018 SHALL, when macro AXIS_PKT_OVERFLOW_CHECK_EN is defined, set overflow=1 on the clock after a transfer occurs while word_count >= MAX_PACKET_BYTES/BYTES_PER_WORD.
REQ-019 SHALL, with AXIS_PKT_OVERFLOW_CHECK_EN defined, hold overflow set until the clock after the transfer carrying s_tlast=1, then clear it.
REQ-020 SHALL, without AXIS_PKT_OVERFLOW_CHECK_EN, tie overflow to 0 and include no overflow logic.

Structure
REQ-021 SHALL place the following in shared package axi_stream_pkg:
- Helper function bytes_per_word(DATA_WIDTH).
- Helper function word_of_byte(byte_idx, BYTES_PER_WORD).
REQ-022 SHALL implement the position tracking (word counter, sop, reached, overflow) as one sub-module, axi_stream_pkt_pos.
REQ-023 SHALL keep the pass-through in the top level.

Verification
REQ-024 SHALL cover: DATA_WIDTH=32, continuous 3-word packet, byte_sel=5 -> reached=1 only on word 1; word_count sequence 0,1,2,0; sop=1 on words 0 and after tlast.
REQ-025 SHALL cover: m_tready low for 3 cycles on word 1 -> word_count holds at 1 and reached holds for all stalled cycles; m_tdata equals s_tdata every cycle.
REQ-026 SHALL cover: two back-to-back single-word packets with tlast=1 -> word_count stays 0 and sop=1 for both.
REQ-027 SHALL cover: rst=0 after word 2 of a 5-word packet -> word_count=0 next cycle; the following accepted word is treated as word 0.
REQ-028 SHALL cover: AXIS_PKT_OVERFLOW_CHECK_EN defined, MAX_PACKET_BYTES=16, DATA_WIDTH=32, 6-word packet -> overflow=1 after the 5th transfer, cleared after tlast.
REQ-029 SHALL cover: TKEEP=0, s_tkeep=4'b0011 -> m_tkeep=4'b1111; with TKEEP=1 -> m_tkeep=4'b0011.
